// File: rtl/slot_game_ctrl_if.sv
// Button, reel and display signals of the slot game controller.
// master drives buttons and reel symbols; slave (the controller) drives reel enables, credit and status.
interface slot_game_ctrl_if #(
   parameter int NUM_REELS = 3,
   parameter int SYM_W     = 3,
   parameter int CW        = 7
);
   logic                       c_in;
   logic                       game_start;
   logic                       stop;
   logic                       cash_out;
   logic [NUM_REELS*SYM_W-1:0] reel_sym;
   logic [NUM_REELS-1:0]       reel_run;
   logic [CW-1:0]              credit;
   logic [CW-1:0]              payout;
   logic                       win;
   logic                       coin_rej;
   logic                       coin_out;
   logic [2:0]                 state;

   modport master (
      output c_in, game_start, stop, cash_out, reel_sym,
      input  reel_run, credit, payout, win, coin_rej, coin_out, state
   );

   modport slave (
      input  c_in, game_start, stop, cash_out, reel_sym,
      output reel_run, credit, payout, win, coin_rej, coin_out, state
   );
endinterface

// File: rtl/slot_game_ctrl.sv
// Slot-machine controller: saturating credit, bet per spin, reel-by-reel stop, payout scoring.
// All outputs registered; a button edge is acted on at the clock edge that samples it.
module slot_game_ctrl #(
   parameter int NUM_REELS   = 3,
   parameter int SYM_W       = 3,
   parameter int CREDIT_MAX  = 99,
   parameter int CREDIT_INIT = 0,
   parameter int BET         = 1,
   parameter int PAY_MULT    = 2,
   localparam int CW         = $clog2(CREDIT_MAX + 1)
) (
   input  logic             clk,
   input  logic             clrb,
   slot_game_ctrl_if.slave  bus
);
   localparam int SW = CW + SYM_W + 1;
   localparam logic [SW-1:0] MAX_W  = SW'(CREDIT_MAX);
   localparam logic [SW-1:0] MULT_W = SW'(PAY_MULT);
   localparam logic [CW-1:0] MAX_C  = CW'(CREDIT_MAX);
   localparam logic [CW-1:0] BET_C  = CW'(BET);
   localparam logic [CW-1:0] INIT_C = CW'(CREDIT_INIT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READY = 3'd1,
      S_SPIN  = 3'd2,
      S_EVAL  = 3'd3,
      S_PAY   = 3'd4,
      S_FULL  = 3'd5
   } state_t;

   state_t               state_q, state_nxt;
   logic [CW-1:0]        credit_q, credit_nxt;
   logic [CW-1:0]        payout_q, payout_nxt;
   logic [NUM_REELS-1:0] reel_run_q, reel_run_nxt;
   logic                 win_q, win_nxt;
   logic                 coin_rej_q, coin_rej_nxt;
   logic                 coin_out_q, coin_out_nxt;
   logic                 c_in_q, start_q, stop_q, cash_q;

   logic                 coin_e, start_e, stop_e, cash_e;
   logic [CW-1:0]        coin_sum, pay_sum, eval_pay;
   logic [NUM_REELS-1:0] run_cleared;
   logic [SYM_W-1:0]     sym0;
   logic                 all_eq;

   function automatic logic [CW-1:0] clamp(input logic [SW-1:0] v);
      return (v > MAX_W) ? MAX_C : v[CW-1:0];
   endfunction

   assign coin_e  = bus.c_in       & ~c_in_q;
   assign start_e = bus.game_start & ~start_q;
   assign stop_e  = bus.stop       & ~stop_q;
   assign cash_e  = bus.cash_out   & ~cash_q;

   assign coin_sum    = clamp(SW'(credit_q) + SW'(coin_e));
   assign pay_sum     = clamp(SW'(credit_q) + SW'(payout_q) + SW'(coin_e));
   // Lowest set bit cleared: one reel stops per STOP edge, index 0 first.
   assign run_cleared = reel_run_q & (reel_run_q - NUM_REELS'(1));
   assign sym0        = bus.reel_sym[SYM_W-1:0];

   always_comb begin
      all_eq = 1'b1;
      for (int i = 1; i < NUM_REELS; i++) begin
         if (bus.reel_sym[i*SYM_W +: SYM_W] != sym0) all_eq = 1'b0;
      end
      eval_pay = all_eq ? clamp(SW'(sym0) * MULT_W) : '0;
   end

   always_ff @(posedge clk) begin
      if (!clrb) begin
         state_q    <= S_IDLE;
         credit_q   <= INIT_C;
         payout_q   <= '0;
         reel_run_q <= '0;
         win_q      <= 1'b0;
         coin_rej_q <= 1'b0;
         coin_out_q <= 1'b0;
         c_in_q     <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         cash_q     <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         credit_q   <= credit_nxt;
         payout_q   <= payout_nxt;
         reel_run_q <= reel_run_nxt;
         win_q      <= win_nxt;
         coin_rej_q <= coin_rej_nxt;
         coin_out_q <= coin_out_nxt;
         c_in_q     <= bus.c_in;
         start_q    <= bus.game_start;
         stop_q     <= bus.stop;
         cash_q     <= bus.cash_out;
      end
   end

   always_comb begin
      state_nxt = S_IDLE;
      case (state_q)
         S_IDLE: begin
            if (cash_e && credit_q != '0) state_nxt = S_IDLE;
            else if (coin_sum == MAX_C)   state_nxt = S_FULL;
            else if (coin_sum >= BET_C)   state_nxt = S_READY;
            else                          state_nxt = S_IDLE;
         end
         S_READY: begin
            if (coin_sum == MAX_C) state_nxt = S_FULL;
            else if (cash_e)       state_nxt = S_IDLE;
            else if (start_e)      state_nxt = S_SPIN;
            else                   state_nxt = S_READY;
         end
         S_SPIN:  state_nxt = (stop_e && run_cleared == '0) ? S_EVAL : S_SPIN;
         S_EVAL:  state_nxt = S_PAY;
         S_PAY: begin
            if (pay_sum == MAX_C)     state_nxt = S_FULL;
            else if (pay_sum >= BET_C) state_nxt = S_READY;
            else                      state_nxt = S_IDLE;
         end
         S_FULL:  state_nxt = cash_e ? S_IDLE : S_FULL;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      credit_nxt   = credit_q;
      payout_nxt   = payout_q;
      reel_run_nxt = reel_run_q;
      win_nxt      = 1'b0;
      coin_rej_nxt = 1'b0;
      coin_out_nxt = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cash_e && credit_q != '0) begin
               credit_nxt   = '0;
               coin_out_nxt = 1'b1;
            end else begin
               credit_nxt = coin_sum;
            end
         end
         S_READY: begin
            if (coin_sum == MAX_C) begin
               credit_nxt = coin_sum;
            end else if (cash_e) begin
               credit_nxt   = '0;
               coin_out_nxt = 1'b1;
            end else if (start_e) begin
               credit_nxt   = coin_sum - BET_C;
               reel_run_nxt = '1;
            end else begin
               credit_nxt = coin_sum;
            end
         end
         S_SPIN: begin
            credit_nxt = coin_sum;
            if (stop_e) reel_run_nxt = run_cleared;
         end
         // WIN is raised on entry to PAY so it is high exactly while STATE reads PAY.
         S_EVAL: begin
            credit_nxt = coin_sum;
            payout_nxt = eval_pay;
            win_nxt    = (eval_pay != '0);
         end
         S_PAY: credit_nxt = pay_sum;
         S_FULL: begin
            if (cash_e) begin
               credit_nxt   = '0;
               coin_out_nxt = 1'b1;
            end else if (coin_e) begin
               coin_rej_nxt = 1'b1;
            end
         end
         default: reel_run_nxt = '0;
      endcase
   end

   assign bus.state    = state_q;
   assign bus.credit   = credit_q;
   assign bus.payout   = payout_q;
   assign bus.reel_run = reel_run_q;
   assign bus.win      = win_q;
   assign bus.coin_rej = coin_rej_q;
   assign bus.coin_out = coin_out_q;
endmodule
